// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-source round-robin burst arbiter:
// FSM state encoding and parameter defaults.
package mux2_rr_arbiter_pkg;

    localparam int W_DEFAULT         = 8;
    localparam int BURST_MAX_DEFAULT = 4;

    // Wide enough for a beat counter up to the largest supported burst (16).
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/mux2_out_reg.sv
// Single-entry output register: loads a beat with its source and last flag,
// and drains when the consumer accepts it with nothing new arriving.
module mux2_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] data,
    input  logic         src,
    input  logic         last,
    output logic         valid,
    output logic [W-1:0] q_data,
    output logic         q_src,
    output logic         q_last
);

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            q_data <= '0;
            q_src  <= 1'b0;
            q_last <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q_data <= data;
            q_src  <= src;
            q_last <= last;
        end else if (drain) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter with burst locking: a grant lasts until the
// source marks last or BURST_MAX beats have passed, then priority flips.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     in_valid,
    input  logic [2*W-1:0] in_data,
    input  logic [1:0]     in_last,
    output logic [1:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_src,
    output logic           out_last,
    input  logic           out_ready,
    output logic           sel
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic             sel_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             g;
    logic             locked;
    logic             can_load;
    logic             xfer;
    logic             rel;
    logic [W-1:0]     mux_data;

    assign g        = (state == LOCK1);
    assign locked   = (state != IDLE);
    assign can_load = !out_valid || out_ready;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_ready = 2'b00;
        if (locked) in_ready[g] = can_load;
    end

    assign xfer = locked && in_valid[g] && in_ready[g];
    assign rel  = xfer && (in_last[g] || cnt == LAST_BEAT);

    assign mux_data = sel ? in_data[W +: W] : in_data[0 +: W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            sel   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                unique case (in_valid)
                    2'b01: begin
                        state_nxt = LOCK0;
                        sel_nxt   = 1'b0;
                    end
                    2'b10: begin
                        state_nxt = LOCK1;
                        sel_nxt   = 1'b1;
                    end
                    2'b11: begin
                        state_nxt = prio ? LOCK1 : LOCK0;
                        sel_nxt   = prio;
                    end
                    default: ;
                endcase
            end
            LOCK0, LOCK1: begin
                if (xfer) cnt_nxt = cnt + CNT_W'(1);
                if (rel) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~g;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mux2_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (xfer),
        .drain  (out_ready),
        .data   (mux_data),
        .src    (g),
        .last   (rel),
        .valid  (out_valid),
        .q_data (out_data),
        .q_src  (out_src),
        .q_last (out_last)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single burst, round robin,
// backpressure and a stalled grant, each checked against hand-derived values.
module tb_mux2_rr_arbiter;

    localparam int W  = 8;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     in_valid;
    logic [2*W-1:0] in_data;
    logic [1:0]     in_last;
    logic [1:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_src;
    logic           out_last;
    logic           out_ready;
    logic           sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .W         (W),
        .BURST_MAX (BM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic apply_reset;
        rst       = 1'b1;
        in_valid  = 2'b00;
        in_data   = '0;
        in_last   = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        settle();
        checks++;
        if ({out_valid, out_data, out_src, out_last, sel, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h s=%b l=%b sel=%b rdy=%b expected all zero",
                     out_valid, out_data, out_src, out_last, sel, in_ready);
        end
        // Lone source1 request, consumer stalled, so the beat sits in the register.
        in_valid  = 2'b10;
        in_data   = {8'hA5, 8'h00};
        out_ready = 1'b0;
        tick(); settle();
        checks++;
        if (sel !== 1'b1 || in_ready !== 2'b10) begin
            errors++;
            $display("FAIL reset_grant1: got sel=%b rdy=%b expected sel=1 rdy=10", sel, in_ready);
        end
        tick(); settle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b1 || in_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_held_beat: got v=%b d=%h s=%b rdy=%b expected v=1 d=a5 s=1 rdy=00",
                     out_valid, out_data, out_src, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_src, out_last, sel, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%h s=%b l=%b sel=%b rdy=%b expected all zero",
                     out_valid, out_data, out_src, out_last, sel, in_ready);
        end
        in_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_burst;
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 2'b01;
        in_data   = {8'h00, 8'h11};
        in_last   = 2'b00;
        settle();
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_idle_ready: got %b expected 00", in_ready);
        end
        tick(); settle();
        checks++;
        if (sel !== 1'b0 || in_ready !== 2'b01 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got sel=%b rdy=%b v=%b expected sel=0 rdy=01 v=0",
                     sel, in_ready, out_valid);
        end
        tick();
        in_data[7:0] = 8'h22;
        settle();
        checks++;
        if ({out_valid, out_data, out_src, out_last} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_beat0: got v=%b d=%h s=%b l=%b expected v=1 d=11 s=0 l=0",
                     out_valid, out_data, out_src, out_last);
        end
        tick();
        in_data[7:0] = 8'h33;
        in_last      = 2'b01;
        settle();
        checks++;
        if ({out_valid, out_data, out_src, out_last} !== {1'b1, 8'h22, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_beat1: got v=%b d=%h s=%b l=%b expected v=1 d=22 s=0 l=0",
                     out_valid, out_data, out_src, out_last);
        end
        tick();
        in_valid = 2'b00;
        in_last  = 2'b00;
        settle();
        checks++;
        if ({out_valid, out_data, out_src, out_last, in_ready} !== {1'b1, 8'h33, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL single_beat2: got v=%b d=%h s=%b l=%b rdy=%b expected v=1 d=33 s=0 l=1 rdy=00",
                     out_valid, out_data, out_src, out_last, in_ready);
        end
        tick(); settle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_drain: got v=%b rdy=%b expected v=0 rdy=00", out_valid, in_ready);
        end
    endtask

    // Both sources always valid: grants of 4 beats alternate 0,1,0,1 with one
    // idle cycle each, giving a period of 5 edges per grant.
    task automatic test_round_robin;
        int seq0 = 0;
        int seq1 = 0;
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 2'b11;
        in_last   = 2'b00;
        in_data   = {8'h80, 8'h00};
        settle();
        for (int k = 1; k <= 20; k++) begin
            logic       x0, x1, exp_src, exp_valid, exp_last;
            logic [1:0] exp_rdy;
            logic [7:0] exp_data;
            int         p, n;
            x0 = in_valid[0] && in_ready[0];
            x1 = in_valid[1] && in_ready[1];
            tick();
            if (x0) seq0++;
            if (x1) seq1++;
            in_data = {8'h80 + 8'(seq1), 8'(seq0)};
            settle();
            p         = (k - 1) % 5;
            n         = (k - 1) / 5;
            exp_src   = 1'(n % 2);
            exp_valid = (p != 0);
            exp_last  = (p == 4);
            exp_data  = (exp_src ? 8'h80 : 8'h00) + 8'((n / 2) * 4 + p - 1);
            exp_rdy   = (p == 4) ? 2'b00 : (exp_src ? 2'b10 : 2'b01);
            checks++;
            if (out_valid !== exp_valid || sel !== exp_src || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ctrl k=%0d: got v=%b sel=%b rdy=%b expected v=%b sel=%b rdy=%b",
                         k, out_valid, sel, in_ready, exp_valid, exp_src, exp_rdy);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data || out_src !== exp_src || out_last !== exp_last) begin
                    errors++;
                    $display("FAIL rr_beat k=%0d: got d=%h s=%b l=%b expected d=%h s=%b l=%b",
                             k, out_data, out_src, out_last, exp_data, exp_src, exp_last);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] rx[$];
        logic [8:0] exp_rx[4];
        logic [7:0] held;
        int         seq = 0;
        exp_rx = '{{1'b0, 8'h40}, {1'b0, 8'h41}, {1'b0, 8'h42}, {1'b1, 8'h43}};
        held   = '0;
        apply_reset();
        for (int c = 0; c <= 14; c++) begin
            logic x0;
            out_ready    = !(c >= 4 && c <= 8);
            in_valid     = {1'b0, seq < 4};
            in_data[7:0] = 8'h40 + 8'(seq);
            settle();
            if (c >= 4 && c <= 8) begin
                if (c == 4) held = out_data;
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 2'b00 || out_data !== 8'h42) begin
                    errors++;
                    $display("FAIL bp_stall c=%0d: got v=%b rdy=%b d=%h expected v=1 rdy=00 d=42",
                             c, out_valid, in_ready, out_data);
                end
                if (c > 4) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL bp_stable c=%0d: got d=%h expected d=%h", c, out_data, held);
                    end
                end
            end
            x0 = in_valid[0] && in_ready[0];
            if (out_valid && out_ready) rx.push_back({out_last, out_data});
            tick();
            if (x0) seq++;
        end
        checks++;
        if (rx.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d beats expected 4", rx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx[i] !== exp_rx[i]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h expected %h", i, rx[i], exp_rx[i]);
                end
            end
        end
    endtask

    task automatic test_starve;
        logic [9:0] rx[$];
        logic [9:0] exp_rx[4];
        logic [7:0] d1[3];
        int         idx1  = 0;
        logic       done0 = 1'b0;
        d1     = '{8'h90, 8'h91, 8'h92};
        exp_rx = '{{1'b1, 1'b0, 8'h90}, {1'b1, 1'b0, 8'h91}, {1'b1, 1'b1, 8'h92}, {1'b0, 1'b1, 8'h10}};
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            logic x0, x1;
            in_valid[1]   = (idx1 < 3) && !(c >= 2 && c <= 4);
            in_data[15:8] = (idx1 < 3) ? d1[idx1] : 8'h00;
            in_last[1]    = (idx1 == 2);
            in_valid[0]   = (c >= 1) && !done0;
            in_data[7:0]  = 8'h10;
            in_last[0]    = 1'b1;
            settle();
            if (c >= 2 && c <= 4) begin
                checks++;
                if (sel !== 1'b1 || in_ready !== 2'b10) begin
                    errors++;
                    $display("FAIL starve_hold c=%0d: got sel=%b rdy=%b expected sel=1 rdy=10",
                             c, sel, in_ready);
                end
            end
            x0 = in_valid[0] && in_ready[0];
            x1 = in_valid[1] && in_ready[1];
            if (out_valid && out_ready) rx.push_back({out_src, out_last, out_data});
            tick();
            if (x0) done0 = 1'b1;
            if (x1) idx1++;
        end
        checks++;
        if (rx.size() != 4) begin
            errors++;
            $display("FAIL starve_count: got %0d beats expected 4", rx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx[i] !== exp_rx[i]) begin
                    errors++;
                    $display("FAIL starve_beat%0d: got %h expected %h", i, rx[i], exp_rx[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter W, default 8, SHALL set the data width of both sources and the output.
REQ-002 Parameter BURST_MAX, default 4, range 1..16, SHALL set the maximum number of beats per grant.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 in_valid  input  2  SHALL carry per-source valid; bit i belongs to source i.
REQ-006 in_data  input  2*W  SHALL carry per-source data; source i occupies bits [i*W +: W].
REQ-007 in_last  input  2  SHALL carry per-source end-of-burst marks.
REQ-008 in_ready  output  2  SHALL carry per-source ready.
REQ-009 out_valid  output  1  SHALL flag that the output register holds a beat.
REQ-010 out_data  output  W  SHALL carry the selected beat.
REQ-011 out_src  output  1  SHALL give the index of the source of the beat in out_data.
REQ-012 out_last  output  1  SHALL flag the final beat of a grant.
REQ-013 out_ready  input  1  SHALL carry downstream ready.
REQ-014 sel  output  1  SHALL carry the current grant index, which drives the 2:1 data select.

Function
REQ-015 FSM states SHALL be IDLE, LOCK0 and LOCK1.
REQ-016 IDLE with in_valid==00 SHALL stay in IDLE.
REQ-017 IDLE with exactly one valid SHALL go to the LOCK state of that source on the next edge.
REQ-018 IDLE with both valid SHALL go to LOCK of source prio, where prio is a 1-bit pointer.
REQ-019 Arbitration SHALL cost exactly one cycle; in_ready SHALL be 00 in IDLE.
REQ-020 In LOCKg, in_ready[g] SHALL equal (!out_valid || out_ready), and in_ready[~g] SHALL be 0.
REQ-021 A transfer SHALL occur when in_valid[g] && in_ready[g].
  - The output register SHALL load in_data[g], g and the release flag on the next edge.
  - Latency from source to output SHALL be 1 cycle.
REQ-022 Beat counter cnt SHALL reset to 0 on entry to LOCK and SHALL increment per transfer.
REQ-023 Release SHALL be the condition (in_last[g] || cnt==BURST_MAX-1) on a transfer.
REQ-024 Release SHALL set out_last=1 for that beat, move the FSM to IDLE, and set prio to ~g.
REQ-025 The grant SHALL hold while in_valid[g]==0 in LOCKg; there is no timeout.
REQ-026 Output register behaviour:
  - out_valid SHALL set on a transfer.
  - out_valid SHALL clear on out_valid && out_ready with no new transfer.
  - Simultaneous drain and load SHALL keep out_valid=1 and sustain 1 beat/cycle.
REQ-027 out_data, out_src and out_last SHALL hold stable while out_valid && !out_ready.
REQ-028 sel SHALL equal g in LOCKg and SHALL hold its last value in IDLE.
REQ-029 When BURST_MAX==1, every transfer SHALL release the grant.
REQ-030 A grant with sustained out_ready SHALL cost one IDLE cycle after release; peak throughput SHALL be BURST_MAX/(BURST_MAX+1).

Reset
REQ-031 While rst is high, these SHALL hold, independent of clk:
  - FSM = IDLE, prio = 0, cnt = 0
  - out_valid = 0, out_data = 0, out_src = 0, out_last = 0
  - sel = 0, in_ready = 00
REQ-032 Reset mid-burst SHALL discard the held beat.
REQ-033 After reset deassertion, the first arbitration SHALL occur on the first edge with rst low.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, LOCK0, LOCK1) and the W and BURST_MAX defaults.
REQ-035 The output register SHALL be a sub-module named mux2_out_reg, containing the valid/data/src/last register with load/drain control.
REQ-036 The data select SHALL be coded as a 2:1 mux on sel with no further combinational logic in the data path.

Verification
REQ-037 Scenario 1: rst high mid-burst with out_valid=1 -> all outputs are 0 immediately, without waiting for a clk edge.
REQ-038 Scenario 2:
  - Stimulus: source0 only, beats 0x11, 0x22, 0x33, with in_last on 0x33, out_ready=1.
  - Response: outputs 0x11, 0x22, 0x33 on consecutive cycles, out_src=0, out_last only on 0x33, then IDLE.
REQ-039 Scenario 3:
  - Stimulus: both sources continuously valid, in_last=0, BURST_MAX=4.
  - Response: grants alternate 0,1,0,1, each exactly 4 beats with out_last on the 4th, and one idle cycle between grants.
REQ-040 Scenario 4: out_ready held low for 5 cycles mid-burst -> out_data stable, in_ready[g]=0, no beat lost or duplicated after release.
REQ-041 Scenario 5: both sources assert valid in the same IDLE cycle after reset -> source0 granted first, and source1 granted on the next arbitration.
REQ-042 Scenario 6: source1 granted, then in_valid[1] drops for 3 cycles -> grant held, source0 starved, and the burst resumes without reordering.
